alu_issue_stage: RTL and testbench
==================================

Name: alu_issue_stage

Overview:
- Upstream issue stage for the 4-stage ALU pipeline.
- Accepts 24-bit instruction words over a valid/ready handshake into a small FIFO and decodes them into the rs1/rs2/rd/func/addr fields the ALU stage 1 consumes.
- Holds back any instruction whose source register is still being produced in the pipeline (RAW hazard); a bubble is emitted in its place.
- Drops illegal opcodes and keeps issue/stall statistics.

Parameters:
- DEPTH, 4, instruction FIFO entries (power of 2, >=2).
- HAZ_DEPTH, 2, number of most recent issue slots whose rd blocks a matching source read.
- CNT_W, 16, width of the statistics counters.

Ports:
- clk1  in  1  single pipeline clock, all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  in_instr is valid.
- in_ready  out  1  FIFO can accept a word this cycle.
- in_instr  in  24  {func[23:20], rd[19:16], rs1[15:12], rs2[11:8], addr[7:0]}.
- hold  in  1  when high, no instruction issues this cycle.
- rs1  out  4  source A register index to ALU.
- rs2  out  4  source B register index to ALU.
- rd  out  4  destination register index to ALU.
- func  out  4  ALU opcode, 0..11 legal; 4'hF on a bubble.
- addr  out  8  memory write address to ALU.
- issue_valid  out  1  outputs carry a real instruction this cycle.
- err_illegal  out  1  sticky: an opcode 12..15 was received.
- issued_cnt  out  CNT_W  count of issued instructions.
- stall_cnt  out  CNT_W  count of hazard-stall cycles.
- fifo_level  out  $clog2(DEPTH+1)  current FIFO occupancy.

Behaviour:
- Reset (sync, rst=1 at posedge):
  - FIFO emptied, scoreboard cleared.
  - issue_valid=0, func=4'hF; rs1, rs2, rd and addr = 0.
  - err_illegal=0, issued_cnt=0, stall_cnt=0, fifo_level=0.
  - Reset asserted mid-operation discards all queued and in-flight scoreboard state.
  - in_ready=0 while rst=1.
- FIFO:
  - in_ready = (fifo_level < DEPTH), combinational from the occupancy register.
  - Push on in_valid && in_ready.
  - Pop when the head is issued or dropped.
  - Push and pop in the same cycle are both performed; level is unchanged.
  - Read and write pointers wrap modulo DEPTH.
  - A word pushed at edge k becomes the head no earlier than after edge k. It can therefore reach the outputs no earlier than after edge k+1, giving a minimum latency of 2 edges from acceptance to issue_valid.
- Scoreboard:
  - HAZ_DEPTH-entry shift register of {v, rd}. Entry 0 is the slot currently on the outputs.
  - Every posedge it shifts: entry 0 loads {1, rd} on an issue, else {0, x}; the oldest entry is discarded.
  - It shifts during hold as well, because the downstream pipeline never stalls.
- Issue decision, evaluated each cycle on the FIFO head:
  - FIFO empty: the outputs present a bubble next cycle.
  - Head func >= 12: the head is popped without issue and err_illegal is set (held until reset). The outputs present a bubble next cycle.
  - hazard = any scoreboard entry with v=1 and rd equal to head rs1 or head rs2.
  - hold=1: no issue and no pop; stall_cnt is not incremented. This applies to illegal heads too: hold=1 blocks the drop.
  - hazard=1 and hold=0: bubble; stall_cnt increments.
  - Otherwise: the head fields are registered onto the outputs, issue_valid=1 next cycle, the head is popped and issued_cnt increments.
- Bubble cycles:
  - issue_valid=0 and func=4'hF.
  - rs1, rs2, rd and addr hold their previous values.
  - The integrator gates the ALU regbank/mem writes with issue_valid.
- Counters saturate at all-ones and do not wrap.
- At most one instruction issues per cycle.
- A self-dependence such as rd=rs1 within the same instruction is not a hazard.

Test Plan:
- Reset, then push {func=0, rd=3, rs1=1, rs2=2, addr=8'h10} -> issue_valid high 2 edges after acceptance; outputs 1/2/3/0/8'h10; issued_cnt=1.
- Push A {func=0, rd=3, rs1=1, rs2=2} then B {func=1, rd=4, rs1=3, rs2=5} back-to-back with HAZ_DEPTH=2 -> A issues, then 2 bubble cycles (func=4'hF, issue_valid=0), then B issues; stall_cnt=2.
- Push 4 independent instructions with hold=1 -> in_ready=0 after the 4th push and fifo_level=4. Release hold -> the 4 issue on consecutive cycles in push order; stall_cnt=0.
- Push a word with func=4'hD followed by a legal word -> the 4'hD word is never issued and err_illegal=1 stays set; the legal word issues next; issued_cnt=1.
- Assert rst for 1 cycle while 3 entries are queued and a hazard stall is active -> all outputs return to reset values, and fifo_level=0 the cycle after.
- Drive 70000 issues with CNT_W=16 -> issued_cnt saturates at 16'hFFFF.

Source files
------------

// File: rtl/alu_issue_stage.sv
// Issue stage ahead of the 4-stage ALU pipeline: buffers instruction words, decodes them,
// holds back RAW-dependent heads behind a bubble, drops illegal opcodes and keeps statistics.
module alu_issue_stage #(
    parameter int DEPTH     = 4,
    parameter int HAZ_DEPTH = 2,
    parameter int CNT_W     = 16
) (
    input  logic                         clk1,
    input  logic                         rst,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [23:0]                  in_instr,
    input  logic                         hold,
    output logic [3:0]                   rs1,
    output logic [3:0]                   rs2,
    output logic [3:0]                   rd,
    output logic [3:0]                   func,
    output logic [7:0]                   addr,
    output logic                         issue_valid,
    output logic                         err_illegal,
    output logic [CNT_W-1:0]             issued_cnt,
    output logic [CNT_W-1:0]             stall_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_level
);

    localparam int PW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH+1);

    logic [23:0]          mem [DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [23:0]          head;
    logic [3:0]           head_func;
    logic [3:0]           head_rd;
    logic [3:0]           head_rs1;
    logic [3:0]           head_rs2;
    logic [7:0]           head_addr;
    logic                 fifo_empty;
    logic                 head_illegal;
    logic                 hazard;
    logic                 push;
    logic                 pop;
    logic                 do_issue;
    logic                 do_drop;
    logic                 do_stall;
    logic [HAZ_DEPTH-1:0] sb_v;
    logic [3:0]           sb_rd [HAZ_DEPTH];

    assign head      = mem[rd_ptr];
    assign head_func = head[23:20];
    assign head_rd   = head[19:16];
    assign head_rs1  = head[15:12];
    assign head_rs2  = head[11:8];
    assign head_addr = head[7:0];

    assign fifo_empty   = (fifo_level == '0);
    assign head_illegal = (head_func >= 4'd12);
    assign in_ready     = !rst && (fifo_level < LW'(DEPTH));
    assign push         = in_valid && in_ready;

    // Illegal heads are discarded before the hazard check, so they never stall.
    assign do_drop  = !fifo_empty && !hold && head_illegal;
    assign do_issue = !fifo_empty && !hold && !head_illegal && !hazard;
    assign do_stall = !fifo_empty && !hold && !head_illegal && hazard;
    assign pop      = do_drop || do_issue;

    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < HAZ_DEPTH; i++) begin
            if (sb_v[i] && ((sb_rd[i] == head_rs1) || (sb_rd[i] == head_rs2))) begin
                hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk1) begin
        if (push) begin
            mem[wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                fifo_level <= fifo_level + 1'b1;
            end else if (pop && !push) begin
                fifo_level <= fifo_level - 1'b1;
            end
        end
    end

    // The scoreboard shifts every cycle, hold included, because downstream never stalls.
    always_ff @(posedge clk1) begin
        if (rst) begin
            sb_v <= '0;
            for (int i = 0; i < HAZ_DEPTH; i++) begin
                sb_rd[i] <= '0;
            end
        end else begin
            for (int i = HAZ_DEPTH - 1; i >= 1; i--) begin
                sb_v[i]  <= sb_v[i-1];
                sb_rd[i] <= sb_rd[i-1];
            end
            sb_v[0]  <= do_issue;
            sb_rd[0] <= head_rd;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            issue_valid <= 1'b0;
            func        <= 4'hF;
            rs1         <= '0;
            rs2         <= '0;
            rd          <= '0;
            addr        <= '0;
        end else if (do_issue) begin
            issue_valid <= 1'b1;
            func        <= head_func;
            rs1         <= head_rs1;
            rs2         <= head_rs2;
            rd          <= head_rd;
            addr        <= head_addr;
        end else begin
            issue_valid <= 1'b0;
            func        <= 4'hF;
        end
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            err_illegal <= 1'b0;
            issued_cnt  <= '0;
            stall_cnt   <= '0;
        end else begin
            if (do_drop) begin
                err_illegal <= 1'b1;
            end
            if (do_issue && (issued_cnt != '1)) begin
                issued_cnt <= issued_cnt + 1'b1;
            end
            if (do_stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed testbench for alu_issue_stage: issue latency, RAW stalls, hold/full FIFO,
// illegal-opcode dropping, mid-operation reset and counter saturation.
module tb_alu_issue_stage;

    localparam int DEPTH     = 4;
    localparam int HAZ_DEPTH = 2;
    localparam int CNT_W     = 8;
    localparam int LW        = $clog2(DEPTH+1);

    logic             clk1;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [23:0]      in_instr;
    logic             hold;
    logic [3:0]       rs1;
    logic [3:0]       rs2;
    logic [3:0]       rd;
    logic [3:0]       func;
    logic [7:0]       addr;
    logic             issue_valid;
    logic             err_illegal;
    logic [CNT_W-1:0] issued_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [LW-1:0]    fifo_level;
    logic [24:0]      out_vec;

    int vectors;
    int miscompares;

    alu_issue_stage #(
        .DEPTH(DEPTH),
        .HAZ_DEPTH(HAZ_DEPTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk1(clk1),
        .rst(rst),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_instr(in_instr),
        .hold(hold),
        .rs1(rs1),
        .rs2(rs2),
        .rd(rd),
        .func(func),
        .addr(addr),
        .issue_valid(issue_valid),
        .err_illegal(err_illegal),
        .issued_cnt(issued_cnt),
        .stall_cnt(stall_cnt),
        .fifo_level(fifo_level)
    );

    // Packed view of the issue outputs: {issue_valid, func, rs1, rs2, rd, addr}.
    assign out_vec = {issue_valid, func, rs1, rs2, rd, addr};

    initial clk1 = 1'b0;
    always #5 clk1 = ~clk1;

    task automatic step();
        @(posedge clk1);
        #1;
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        in_valid = 1'b0;
        hold     = 1'b0;
        in_instr = '0;
        step();
        step();
        vectors++;
        if (out_vec !== 25'h0F00000) begin
            $display("[TB] FAIL reset_outputs: got %h expected %h", out_vec, 25'h0F00000);
            miscompares++;
        end
        vectors++;
        if ({err_illegal, issued_cnt, stall_cnt, fifo_level} !== '0) begin
            $display("[TB] FAIL reset_status: err=%b issued=%0d stall=%0d level=%0d expected all zero",
                     err_illegal, issued_cnt, stall_cnt, fifo_level);
            miscompares++;
        end
        vectors++;
        if (in_ready !== 1'b0) begin
            $display("[TB] FAIL reset_in_ready: got %b expected 0", in_ready);
            miscompares++;
        end
        rst = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            $display("[TB] FAIL ready_after_reset: got %b expected 1", in_ready);
            miscompares++;
        end
        step();
    endtask

    task automatic test_single_issue();
        in_valid = 1'b1;
        in_instr = {4'h0, 4'd3, 4'd1, 4'd2, 8'h10};
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_vec !== {1'b0, 4'hF, 4'd0, 4'd0, 4'd0, 8'h00} || fifo_level !== 3'd1) begin
            $display("[TB] FAIL single_first_edge: got %h level %0d expected %h level 1",
                     out_vec, fifo_level, {1'b0, 4'hF, 4'd0, 4'd0, 4'd0, 8'h00});
            miscompares++;
        end
        step();
        vectors++;
        if (out_vec !== {1'b1, 4'h0, 4'd1, 4'd2, 4'd3, 8'h10}) begin
            $display("[TB] FAIL single_issue: got %h expected %h", out_vec, {1'b1, 4'h0, 4'd1, 4'd2, 4'd3, 8'h10});
            miscompares++;
        end
        vectors++;
        if (issued_cnt !== 8'd1 || fifo_level !== 3'd0) begin
            $display("[TB] FAIL single_counts: issued %0d level %0d expected 1 and 0", issued_cnt, fifo_level);
            miscompares++;
        end
        step();
        vectors++;
        if (out_vec !== {1'b0, 4'hF, 4'd1, 4'd2, 4'd3, 8'h10}) begin
            $display("[TB] FAIL single_bubble_hold: got %h expected %h", out_vec, {1'b0, 4'hF, 4'd1, 4'd2, 4'd3, 8'h10});
            miscompares++;
        end
    endtask

    task automatic test_raw_hazard();
        step();
        step();
        in_valid = 1'b1;
        in_instr = {4'h0, 4'd3, 4'd1, 4'd2, 8'h11};
        step();
        in_instr = {4'h1, 4'd4, 4'd3, 4'd5, 8'h22};
        step();
        in_valid = 1'b0;
        vectors++;
        if (out_vec !== {1'b1, 4'h0, 4'd1, 4'd2, 4'd3, 8'h11}) begin
            $display("[TB] FAIL raw_a_issue: got %h expected %h", out_vec, {1'b1, 4'h0, 4'd1, 4'd2, 4'd3, 8'h11});
            miscompares++;
        end
        for (int i = 1; i <= 2; i++) begin
            step();
            vectors++;
            if (out_vec !== {1'b0, 4'hF, 4'd1, 4'd2, 4'd3, 8'h11} || stall_cnt !== 8'(i)) begin
                $display("[TB] FAIL raw_bubble_%0d: got %h stall %0d expected %h stall %0d",
                         i, out_vec, stall_cnt, {1'b0, 4'hF, 4'd1, 4'd2, 4'd3, 8'h11}, i);
                miscompares++;
            end
        end
        step();
        vectors++;
        if (out_vec !== {1'b1, 4'h1, 4'd3, 4'd5, 4'd4, 8'h22}) begin
            $display("[TB] FAIL raw_b_issue: got %h expected %h", out_vec, {1'b1, 4'h1, 4'd3, 4'd5, 4'd4, 8'h22});
            miscompares++;
        end
        vectors++;
        if (stall_cnt !== 8'd2 || issued_cnt !== 8'd3) begin
            $display("[TB] FAIL raw_counts: stall %0d issued %0d expected 2 and 3", stall_cnt, issued_cnt);
            miscompares++;
        end
    endtask

    task automatic test_hold_fill();
        step();
        hold = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1;
            in_instr = {4'(i + 2), 4'(i + 6), 4'd10, 4'd11, 8'(8'h20 + i)};
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (fifo_level !== 3'd4 || in_ready !== 1'b0 || issue_valid !== 1'b0) begin
            $display("[TB] FAIL hold_full: level %0d ready %b valid %b expected 4 0 0",
                     fifo_level, in_ready, issue_valid);
            miscompares++;
        end
        in_valid = 1'b1;
        in_instr = {4'h9, 4'd9, 4'd9, 4'd9, 8'h99};
        step();
        in_valid = 1'b0;
        vectors++;
        if (fifo_level !== 3'd4) begin
            $display("[TB] FAIL full_push_ignored: level %0d expected 4", fifo_level);
            miscompares++;
        end
        hold = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            vectors++;
            if (out_vec !== {1'b1, 4'(i + 2), 4'd10, 4'd11, 4'(i + 6), 8'(8'h20 + i)}) begin
                $display("[TB] FAIL hold_drain_%0d: got %h expected %h",
                         i, out_vec, {1'b1, 4'(i + 2), 4'd10, 4'd11, 4'(i + 6), 8'(8'h20 + i)});
                miscompares++;
            end
        end
        vectors++;
        if (fifo_level !== 3'd0 || issued_cnt !== 8'd7 || stall_cnt !== 8'd2) begin
            $display("[TB] FAIL hold_counts: level %0d issued %0d stall %0d expected 0 7 2",
                     fifo_level, issued_cnt, stall_cnt);
            miscompares++;
        end
    endtask

    task automatic test_illegal();
        step();
        in_valid = 1'b1;
        in_instr = {4'hD, 4'd7, 4'd1, 4'd2, 8'h33};
        step();
        in_instr = {4'h6, 4'd1, 4'd2, 4'd3, 8'h44};
        step();
        in_valid = 1'b0;
        vectors++;
        if (err_illegal !== 1'b1 || issue_valid !== 1'b0 || fifo_level !== 3'd1) begin
            $display("[TB] FAIL illegal_drop: err %b valid %b level %0d expected 1 0 1",
                     err_illegal, issue_valid, fifo_level);
            miscompares++;
        end
        step();
        vectors++;
        if (out_vec !== {1'b1, 4'h6, 4'd2, 4'd3, 4'd1, 8'h44} || issued_cnt !== 8'd8) begin
            $display("[TB] FAIL illegal_next_issue: got %h issued %0d expected %h issued 8",
                     out_vec, issued_cnt, {1'b1, 4'h6, 4'd2, 4'd3, 4'd1, 8'h44});
            miscompares++;
        end
        hold     = 1'b1;
        in_valid = 1'b1;
        in_instr = {4'hE, 4'd1, 4'd1, 4'd1, 8'h55};
        step();
        in_valid = 1'b0;
        step();
        step();
        vectors++;
        if (fifo_level !== 3'd1 || err_illegal !== 1'b1) begin
            $display("[TB] FAIL hold_blocks_drop: level %0d err %b expected 1 1", fifo_level, err_illegal);
            miscompares++;
        end
        hold = 1'b0;
        step();
        vectors++;
        if (fifo_level !== 3'd0 || issue_valid !== 1'b0 || issued_cnt !== 8'd8) begin
            $display("[TB] FAIL illegal_after_hold: level %0d valid %b issued %0d expected 0 0 8",
                     fifo_level, issue_valid, issued_cnt);
            miscompares++;
        end
    endtask

    task automatic test_mid_reset();
        step();
        in_valid = 1'b1;
        in_instr = {4'h0, 4'd5, 4'd1, 4'd2, 8'h50};
        step();
        in_instr = {4'h1, 4'd6, 4'd5, 4'd2, 8'h51};
        step();
        in_instr = {4'h2, 4'd7, 4'd1, 4'd2, 8'h52};
        step();
        in_instr = {4'h3, 4'd8, 4'd1, 4'd2, 8'h53};
        step();
        in_valid = 1'b0;
        vectors++;
        if (fifo_level !== 3'd3 || stall_cnt !== 8'd4 || out_vec !== {1'b0, 4'hF, 4'd1, 4'd2, 4'd5, 8'h50}) begin
            $display("[TB] FAIL pre_reset_stall: level %0d stall %0d out %h expected 3 4 %h",
                     fifo_level, stall_cnt, out_vec, {1'b0, 4'hF, 4'd1, 4'd2, 4'd5, 8'h50});
            miscompares++;
        end
        rst = 1'b1;
        step();
        vectors++;
        if (out_vec !== 25'h0F00000 || {err_illegal, issued_cnt, stall_cnt, fifo_level} !== '0 || in_ready !== 1'b0) begin
            $display("[TB] FAIL mid_reset: out %h err %b issued %0d stall %0d level %0d ready %b expected reset values",
                     out_vec, err_illegal, issued_cnt, stall_cnt, fifo_level, in_ready);
            miscompares++;
        end
        rst = 1'b0;
        step();
        vectors++;
        if (fifo_level !== 3'd0 || issue_valid !== 1'b0 || in_ready !== 1'b1) begin
            $display("[TB] FAIL post_reset: level %0d valid %b ready %b expected 0 0 1",
                     fifo_level, issue_valid, in_ready);
            miscompares++;
        end
        in_valid = 1'b1;
        in_instr = {4'h4, 4'd9, 4'd5, 4'd6, 8'h60};
        step();
        in_valid = 1'b0;
        step();
        vectors++;
        if (out_vec !== {1'b1, 4'h4, 4'd5, 4'd6, 4'd9, 8'h60} || issued_cnt !== 8'd1) begin
            $display("[TB] FAIL post_reset_issue: got %h issued %0d expected %h issued 1",
                     out_vec, issued_cnt, {1'b1, 4'h4, 4'd5, 4'd6, 4'd9, 8'h60});
            miscompares++;
        end
    endtask

    task automatic test_saturation();
        in_valid = 1'b1;
        in_instr = {4'h2, 4'd0, 4'd1, 4'd2, 8'h77};
        for (int i = 0; i < 254; i++) begin
            step();
        end
        vectors++;
        if (issued_cnt !== 8'hFE || fifo_level !== 3'd1 || issue_valid !== 1'b1) begin
            $display("[TB] FAIL stream_pre_sat: issued %0h level %0d valid %b expected fe 1 1",
                     issued_cnt, fifo_level, issue_valid);
            miscompares++;
        end
        step();
        vectors++;
        if (issued_cnt !== 8'hFF) begin
            $display("[TB] FAIL stream_sat: issued %0h expected ff", issued_cnt);
            miscompares++;
        end
        for (int i = 0; i < 40; i++) begin
            step();
        end
        in_valid = 1'b0;
        vectors++;
        if (issued_cnt !== 8'hFF || stall_cnt !== 8'd0) begin
            $display("[TB] FAIL stream_no_wrap: issued %0h stall %0d expected ff 0", issued_cnt, stall_cnt);
            miscompares++;
        end
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        in_valid    = 1'b0;
        in_instr    = '0;
        hold        = 1'b0;
        test_reset();
        test_single_issue();
        test_raw_hazard();
        test_hold_fill();
        test_illegal();
        test_mid_reset();
        test_saturation();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
